// File: rtl/rsa_top_axi4lite.sv
// AXI4-Lite peripheral computing message^exponent mod modulus (32-bit).
// Constant-time right-to-left square-and-multiply on one bit-serial modular multiplier.
module rsa_top_axi4lite #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] i_axi_awaddr,
    input  logic          i_axi_awvalid,
    output logic          o_axi_awready,
    input  logic [3:0]    i_axi_awcache,
    input  logic [2:0]    i_axi_awprot,
    input  logic [DW-1:0] i_axi_wdata,
    input  logic [3:0]    i_axi_wstrb,
    input  logic          i_axi_wvalid,
    output logic          o_axi_wready,
    output logic [1:0]    o_axi_bresp,
    output logic          o_axi_bvalid,
    input  logic          i_axi_bready,
    input  logic [AW-1:0] i_axi_araddr,
    input  logic          i_axi_arvalid,
    output logic          o_axi_arready,
    input  logic [3:0]    i_axi_arcache,
    input  logic [2:0]    i_axi_arprot,
    output logic [DW-1:0] o_axi_rdata,
    output logic [1:0]    o_axi_rresp,
    output logic          o_axi_rvalid,
    input  logic          i_axi_rready
);

    localparam logic [5:0] A_NAME0   = 6'h00;
    localparam logic [5:0] A_NAME1   = 6'h01;
    localparam logic [5:0] A_VERSION = 6'h02;
    localparam logic [5:0] A_CTRL    = 6'h08;
    localparam logic [5:0] A_STATUS  = 6'h09;
    localparam logic [5:0] A_MSG     = 6'h10;
    localparam logic [5:0] A_EXP     = 6'h11;
    localparam logic [5:0] A_MOD     = 6'h12;
    localparam logic [5:0] A_RESULT  = 6'h13;

    typedef enum logic [1:0] {S_IDLE, S_REDUCE, S_EXP, S_DONE} state_e;

    logic unused_sigs;
    assign unused_sigs = ^{i_axi_awcache, i_axi_awprot, i_axi_arcache, i_axi_arprot,
                           i_axi_awaddr, i_axi_araddr};

    // Reset asserts immediately, releases two clocks after rst_i falls.
    logic [1:0] rst_sync_q;
    logic       rst_int;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rst_sync_q <= '1;
        else       rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
    assign rst_int = rst_sync_q[1];

    state_e       state_q;
    logic [5:0]   cnt_q;
    logic [4:0]   bit_cnt_q;
    logic         phase_q;
    logic [31:0]  m_q, base_q, r_q, e_q, a_sh_q, result_q;
    logic [32:0]  p_q;
    logic         ready_q, valid_q;

    logic         awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic         aw_full_q, aw_full_d, w_full_q, w_full_d;
    logic         bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [5:0]   awaddr_q, awaddr_d;
    logic [31:0]  wdata_q, wdata_d, rdata_q, rdata_d, rd_mux;
    logic [3:0]   wstrb_q, wstrb_d;
    logic [31:0]  msg_q, msg_d, exp_q, exp_d, mod_q, mod_d;
    logic         wr_en, idle, start;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = nw[8*i +: 8];
        end
        return res;
    endfunction

    assign idle  = (state_q == S_IDLE);
    assign wr_en = aw_full_q && w_full_q;
    assign start = wr_en && idle && (awaddr_q == A_CTRL) && wstrb_q[0] && wdata_q[0];

    always_comb begin
        rd_mux = '0;
        case (i_axi_araddr[7:2])
            A_NAME0:   rd_mux = 32'h7273615F;
            A_NAME1:   rd_mux = 32'h6D6F6465;
            A_VERSION: rd_mux = 32'h00000001;
            A_STATUS:  rd_mux = {30'd0, valid_q, ready_q};
            A_MSG:     rd_mux = msg_q;
            A_EXP:     rd_mux = exp_q;
            A_MOD:     rd_mux = mod_q;
            A_RESULT:  rd_mux = result_q;
            default:   rd_mux = '0;
        endcase
    end

    always_comb begin
        aw_full_d = aw_full_q;
        awaddr_d  = awaddr_q;
        w_full_d  = w_full_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        msg_d     = msg_q;
        exp_d     = exp_q;
        mod_d     = mod_q;

        if (i_axi_awvalid && awready_q) begin
            aw_full_d = 1'b1;
            awaddr_d  = i_axi_awaddr[7:2];
        end
        if (i_axi_wvalid && wready_q) begin
            w_full_d = 1'b1;
            wdata_d  = i_axi_wdata;
            wstrb_d  = i_axi_wstrb;
        end
        if (wr_en) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (idle) begin
                case (awaddr_q)
                    A_MSG:   msg_d = merge(msg_q, wdata_q, wstrb_q);
                    A_EXP:   exp_d = merge(exp_q, wdata_q, wstrb_q);
                    A_MOD:   mod_d = merge(mod_q, wdata_q, wstrb_q);
                    default: ;
                endcase
            end
        end
        if (bvalid_q && i_axi_bready) bvalid_d = 1'b0;
        // One write outstanding: both readies stay low until the response is taken.
        awready_d = !aw_full_d && !bvalid_d;
        wready_d  = !w_full_d && !bvalid_d;

        if (i_axi_arvalid && arready_q) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
        end else if (rvalid_q && i_axi_rready) begin
            rvalid_d = 1'b0;
        end
        arready_d = !rvalid_d;
    end

    always_ff @(posedge clk_i or posedge rst_int) begin
        if (rst_int) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            msg_q     <= '0;
            exp_q     <= '0;
            mod_q     <= '0;
        end else begin
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            msg_q     <= msg_d;
            exp_q     <= exp_d;
            mod_q     <= mod_d;
        end
    end

    assign o_axi_awready = awready_q;
    assign o_axi_wready  = wready_q;
    assign o_axi_arready = arready_q;
    assign o_axi_bvalid  = bvalid_q;
    assign o_axi_rvalid  = rvalid_q;
    assign o_axi_rdata   = rdata_q;
    assign o_axi_bresp   = 2'b00;
    assign o_axi_rresp   = 2'b00;

    // Restoring-division step (REDUCE) and interleaved modular-multiply step (EXP).
    logic [32:0] m_ext, div_sh, div_next, mul_p2, mul_p2r, mul_p3, mul_next;
    always_comb begin
        m_ext    = {1'b0, m_q};
        div_sh   = {p_q[31:0], a_sh_q[31]};
        div_next = (div_sh >= m_ext) ? div_sh - m_ext : div_sh;
        mul_p2   = {p_q[31:0], 1'b0};
        mul_p2r  = (mul_p2 >= m_ext) ? mul_p2 - m_ext : mul_p2;
        mul_p3   = a_sh_q[31] ? mul_p2r + {1'b0, base_q} : mul_p2r;
        mul_next = (mul_p3 >= m_ext) ? mul_p3 - m_ext : mul_p3;
    end

    always_ff @(posedge clk_i or posedge rst_int) begin
        if (rst_int) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            phase_q   <= 1'b0;
            m_q       <= '0;
            base_q    <= '0;
            r_q       <= '0;
            e_q       <= '0;
            a_sh_q    <= '0;
            p_q       <= '0;
            result_q  <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        m_q     <= mod_q;
                        e_q     <= exp_q;
                        a_sh_q  <= msg_q;
                        p_q     <= '0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        valid_q <= 1'b0;
                        state_q <= S_REDUCE;
                    end
                end
                S_REDUCE: begin
                    p_q    <= div_next;
                    a_sh_q <= {a_sh_q[30:0], 1'b0};
                    cnt_q  <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        base_q    <= div_next[31:0];
                        r_q       <= (m_q == 32'd1) ? 32'd0 : 32'd1;
                        cnt_q     <= '0;
                        phase_q   <= 1'b0;
                        bit_cnt_q <= '0;
                        state_q   <= S_EXP;
                    end
                end
                S_EXP: begin
                    // Phase 0 computes r*base, phase 1 base*base; each is 1 load + 32 steps.
                    if (cnt_q == 6'd0) begin
                        p_q    <= '0;
                        a_sh_q <= phase_q ? base_q : r_q;
                        cnt_q  <= 6'd1;
                    end else begin
                        p_q    <= mul_next;
                        a_sh_q <= {a_sh_q[30:0], 1'b0};
                        cnt_q  <= cnt_q + 6'd1;
                        if (cnt_q == 6'd32) begin
                            cnt_q <= '0;
                            if (!phase_q) begin
                                if (e_q[0]) r_q <= mul_next[31:0];
                                phase_q <= 1'b1;
                            end else begin
                                base_q    <= mul_next[31:0];
                                phase_q   <= 1'b0;
                                e_q       <= {1'b0, e_q[31:1]};
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                                if (bit_cnt_q == 5'd31) state_q <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    result_q <= (m_q == 32'd0) ? 32'd0 : r_q;
                    ready_q  <= 1'b1;
                    valid_q  <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_top_axi4lite.sv
// Directed bench for rsa_top_axi4lite: register map, exponentiation vectors,
// fixed latency, busy-write protection and mid-operation reset.
module tb_rsa_top_axi4lite;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr, wdata, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_commit = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rsa_top_axi4lite #(.AW(32), .DW(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .i_axi_awaddr(awaddr), .i_axi_awvalid(awvalid), .o_axi_awready(awready),
        .i_axi_awcache(4'h0), .i_axi_awprot(3'h0),
        .i_axi_wdata(wdata), .i_axi_wstrb(wstrb), .i_axi_wvalid(wvalid), .o_axi_wready(wready),
        .o_axi_bresp(bresp), .o_axi_bvalid(bvalid), .i_axi_bready(bready),
        .i_axi_araddr(araddr), .i_axi_arvalid(arvalid), .o_axi_arready(arready),
        .i_axi_arcache(4'h0), .i_axi_arprot(3'h0),
        .o_axi_rdata(rdata), .o_axi_rresp(rresp), .o_axi_rvalid(rvalid), .i_axi_rready(rready)
    );

    // Bus tasks start and end on a falling edge; last_commit is the clock edge
    // on which the register write took effect (bvalid rises on that edge).
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit aw_hs = 1'b0;
        bit w_hs = 1'b0;
        int t = 0;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        while (!(aw_hs && w_hs) && t < 50) begin
            if (awvalid && awready) aw_hs = 1'b1;
            if (wvalid && wready) w_hs = 1'b1;
            @(negedge clk); t++;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs) wvalid = 1'b0;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        t = 0; bready = 1'b1;
        while (!bvalid && t < 50) begin @(negedge clk); t++; end
        last_commit = cyc;
        n_cmp++;
        if (!(aw_hs && w_hs) || bvalid !== 1'b1 || bresp !== 2'b00) begin
            $display("FAIL write_resp addr=%h: got aw=%0d w=%0d bvalid=%b bresp=%b, want 1 1 1 00",
                     addr, aw_hs, w_hs, bvalid, bresp);
            n_fail++;
        end
        @(negedge clk); bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit hs = 1'b0;
        int t = 0;
        araddr = addr; arvalid = 1'b1;
        while (!hs && t < 50) begin
            if (arready) hs = 1'b1;
            @(negedge clk); t++;
        end
        arvalid = 1'b0;
        n_cmp++;
        if (!hs || rvalid !== 1'b1) begin
            $display("FAIL read_handshake addr=%h: got hs=%0d rvalid=%b, want 1 1", addr, hs, rvalid);
            n_fail++;
        end
        data = rdata; resp = rresp;
        rready = 1'b1; @(negedge clk); rready = 1'b0;
    endtask

    task automatic poll_ready(output bit ok);
        logic [31:0] d;
        logic [1:0]  r;
        ok = 1'b0;
        for (int i = 0; i < 1500 && !ok; i++) begin
            axi_read(32'h24, d, r);
            if (d[0]) ok = 1'b1;
        end
    endtask

    task automatic wait_until(input int edge_num);
        while (cyc < edge_num) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic [1:0]  r;
        int t = 0;
        rst = 1'b1;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== '0) begin
            $display("FAIL reset_outputs: got aw=%b w=%b ar=%b b=%b r=%b rdata=%h, want all 0",
                     awready, wready, arready, bvalid, rvalid, rdata);
            n_fail++;
        end
        rst = 1'b0;
        while (!(awready && wready && arready) && t < 6) begin @(negedge clk); t++; end
        n_cmp++;
        if ({awready, wready, arready} !== 3'b111) begin
            $display("FAIL reset_release_ready: got %b, want 111", {awready, wready, arready});
            n_fail++;
        end
        axi_read(32'h24, d, r);
        n_cmp++;
        if (d !== 32'h1) begin $display("FAIL reset_status: got %h, want 00000001", d); n_fail++; end
        axi_read(32'h4C, d, r);
        n_cmp++;
        if (d !== 32'h0) begin $display("FAIL reset_result: got %h, want 00000000", d); n_fail++; end
    endtask

    task automatic test_ids;
        logic [31:0] addrs [5];
        logic [31:0] exps [5];
        logic [31:0] d;
        logic [1:0]  r;
        addrs = '{32'h00, 32'h04, 32'h08, 32'h90, 32'h20};
        exps  = '{32'h7273615F, 32'h6D6F6465, 32'h00000001, 32'h0, 32'h0};
        for (int i = 0; i < 5; i++) begin
            axi_read(addrs[i], d, r);
            n_cmp++;
            if (d !== exps[i] || r !== 2'b00) begin
                $display("FAIL id_read addr=%h: got %h resp %b, want %h resp 00", addrs[i], d, r, exps[i]);
                n_fail++;
            end
        end
    endtask

    task automatic test_wstrb;
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(32'h40, 32'hAABBCCDD, 4'hF);
        axi_write(32'h40, 32'h11223344, 4'b0101);
        axi_read(32'h40, d, r);
        n_cmp++;
        if (d !== 32'hAA22CC44) begin $display("FAIL wstrb_merge: got %h, want aa22cc44", d); n_fail++; end
    endtask

    task automatic test_vector(input logic [31:0] msg, input logic [31:0] e,
                               input logic [31:0] m, input logic [31:0] want);
        logic [31:0] d;
        logic [1:0]  r;
        bit ok;
        axi_write(32'h40, msg, 4'hF);
        axi_write(32'h44, e, 4'hF);
        axi_write(32'h48, m, 4'hF);
        axi_write(32'h20, 32'h1, 4'hF);
        axi_read(32'h24, d, r);
        n_cmp++;
        if (d !== 32'h0) begin $display("FAIL vec_busy_status: got %h, want 00000000", d); n_fail++; end
        poll_ready(ok);
        axi_read(32'h24, d, r);
        n_cmp++;
        if (!ok || d !== 32'h3) begin
            $display("FAIL vec_done_status: got %h ok=%0d, want 00000003", d, ok); n_fail++;
        end
        axi_read(32'h4C, d, r);
        n_cmp++;
        if (d !== want) begin
            $display("FAIL vec_result (%h,%h,%h): got %h, want %h", msg, e, m, d, want); n_fail++;
        end
    endtask

    // Status sampled by a read whose AR handshake lands on edge start+off.
    task automatic test_timing(input logic [31:0] e, input int off, input logic [31:0] want);
        logic [31:0] d;
        logic [1:0]  r;
        int s0;
        bit ok;
        axi_write(32'h40, 32'h00000003, 4'hF);
        axi_write(32'h44, e, 4'hF);
        axi_write(32'h48, 32'h00010001, 4'hF);
        axi_write(32'h20, 32'h1, 4'hF);
        s0 = last_commit;
        wait_until(s0 + off - 1);
        axi_read(32'h24, d, r);
        n_cmp++;
        if (d !== want) begin
            $display("FAIL latency exp=%h edge=+%0d: got %h, want %h", e, off, d, want); n_fail++;
        end
        poll_ready(ok);
    endtask

    task automatic test_busy;
        logic [31:0] d;
        logic [1:0]  r;
        int s0;
        axi_write(32'h40, 32'h4, 4'hF);
        axi_write(32'h44, 32'hD, 4'hF);
        axi_write(32'h48, 32'h1F1, 4'hF);
        axi_write(32'h20, 32'h1, 4'hF);
        s0 = last_commit;
        axi_write(32'h48, 32'h7, 4'hF);
        axi_read(32'h48, d, r);
        n_cmp++;
        if (d !== 32'h1F1) begin $display("FAIL busy_modulus: got %h, want 000001f1", d); n_fail++; end
        axi_write(32'h20, 32'h1, 4'hF);
        wait_until(s0 + 2145);
        axi_read(32'h24, d, r);
        n_cmp++;
        if (d !== 32'h3) begin $display("FAIL busy_restart_ignored: got %h, want 00000003", d); n_fail++; end
        axi_read(32'h4C, d, r);
        n_cmp++;
        if (d !== 32'h1BD) begin $display("FAIL busy_result: got %h, want 000001bd", d); n_fail++; end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        logic [1:0]  r;
        int s0;
        int t = 0;
        axi_write(32'h40, 32'h01234567, 4'hF);
        axi_write(32'h44, 32'h89ABCDEF, 4'hF);
        axi_write(32'h48, 32'h11111111, 4'hF);
        axi_write(32'h20, 32'h1, 4'hF);
        s0 = last_commit;
        axi_read(32'h24, d, r);
        wait_until(s0 + 500);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== '0) begin
            $display("FAIL midreset_outputs: got aw=%b w=%b ar=%b b=%b r=%b rdata=%h, want all 0",
                     awready, wready, arready, bvalid, rvalid, rdata);
            n_fail++;
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        while (!(awready && arready) && t < 6) begin @(negedge clk); t++; end
        axi_read(32'h24, d, r);
        n_cmp++;
        if (d !== 32'h1) begin $display("FAIL midreset_status: got %h, want 00000001", d); n_fail++; end
        axi_read(32'h4C, d, r);
        n_cmp++;
        if (d !== 32'h0) begin $display("FAIL midreset_result: got %h, want 00000000", d); n_fail++; end
        test_vector(32'd2, 32'd2, 32'd5, 32'd4);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ids();
        test_wstrb();
        test_vector(32'd1, 32'd2, 32'd5, 32'd1);
        test_vector(32'd1, 32'd2, 32'd3, 32'd1);
        test_vector(32'd2, 32'd2, 32'd5, 32'd4);
        test_vector(32'd2, 32'd2, 32'd3, 32'd1);
        test_vector(32'd4, 32'hD, 32'h1F1, 32'h1BD);
        test_vector(32'h01234567, 32'h89ABCDEF, 32'h11111111, 32'h0D9EF081);
        test_vector(32'h30000000, 32'hC0000000, 32'h00A00001, 32'h0000CC3F);
        test_vector(32'd5, 32'd0, 32'd7, 32'd1);
        test_vector(32'd5, 32'd3, 32'd1, 32'd0);
        test_vector(32'd5, 32'd3, 32'd0, 32'd0);
        test_timing(32'h00000000, 2145, 32'h0);
        test_timing(32'h00000000, 2146, 32'h3);
        test_timing(32'hFFFFFFFF, 2145, 32'h0);
        test_timing(32'hFFFFFFFF, 2146, 32'h3);
        test_busy();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
